// File: rtl/flappy_pkg.sv
// Shared scheduler definitions: state encoding, default timing constants
// and small state-classification helpers.
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_INPUT     = 3'd2,
    ST_ACTION    = 3'd3,
    ST_DISPLAY   = 3'd4
  } sched_state_e;

  localparam int unsigned FRAME_DIV_DEF = 1000000;
  localparam int unsigned WDOG_CYC_DEF  = 4096;
  localparam int unsigned FRAME_CNT_W   = 16;

  // True for the three stages that own an enable/done handshake.
  function automatic logic is_stage(input sched_state_e s);
    return (s == ST_INPUT) || (s == ST_ACTION) || (s == ST_DISPLAY);
  endfunction

  // Stage that follows a completed stage; DISPLAY closes the frame.
  function automatic sched_state_e next_stage(input sched_state_e s);
    case (s)
      ST_INPUT:  return ST_ACTION;
      ST_ACTION: return ST_DISPLAY;
      default:   return ST_WAIT_TICK;
    endcase
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame divider: counts 0..FRAME_DIV-1 while enabled and flags the
// terminal-count cycle as a one-cycle tick before wrapping to 0.
module frame_timer
  import flappy_pkg::*;
#(
  parameter int unsigned FRAME_DIV = FRAME_DIV_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ena_i,
  output logic tick_o
);

  localparam int unsigned CW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = ena_i && (cnt_q == TERM);

  // Next count: advance while enabled, wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (ena_i) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: sequences INPUT -> ACTION -> DISPLAY once per frame
// tick, tracking overrun ticks and counting completed frames.
// Optional stage watchdog enabled by defining FRAME_SCHED_WDOG_EN.
module frame_scheduler
  import flappy_pkg::*;
#(
  parameter int unsigned FRAME_DIV = FRAME_DIV_DEF,
  parameter int unsigned WDOG_CYC  = WDOG_CYC_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ena_i,
  input  logic        pause_i,
  input  logic        d_inp_i,
  input  logic        d_act_i,
  input  logic        d_disp_i,
  output logic        e_inp_o,
  output logic        e_act_o,
  output logic        e_disp_o,
  output logic        frame_o,
  output logic [15:0] frame_cnt_o,
  output logic        overrun_o,
  output logic        wdog_err_o,
  output logic [2:0]  state_o
);

  sched_state_e            state_q, state_d;
  logic                    pend_q, pend_d;
  logic                    ovr_q, ovr_d;
  logic                    frame_q, frame_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q;
  logic [2:0]              en_q;
  logic                    tick;
  logic                    timer_run;
  logic                    done_cur;
  logic                    wdog_to;

  assign timer_run = ena_i && (state_q != ST_IDLE);

  frame_timer #(.FRAME_DIV(FRAME_DIV)) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ena_i   (timer_run),
    .tick_o  (tick)
  );

  assign done_cur = ((state_q == ST_INPUT)   && d_inp_i) ||
                    ((state_q == ST_ACTION)  && d_act_i) ||
                    ((state_q == ST_DISPLAY) && d_disp_i);

`ifdef FRAME_SCHED_WDOG_EN
  logic [15:0] wdog_q;
  logic        wdog_err_q;

  assign wdog_to    = (wdog_q == 16'(WDOG_CYC - 1));
  assign wdog_err_o = wdog_err_q;

  // Stage-age counter restarts on every state change; a timeout only
  // latches the error when the matching done is absent that cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else if (ena_i) begin
      if ((state_d != state_q) || !is_stage(state_q)) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + 16'd1;
      end
      if (is_stage(state_q) && !done_cur && wdog_to) begin
        wdog_err_q <= 1'b1;
      end
    end
  end
`else
  assign wdog_to    = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

  // Next-state, pending-tick and overrun logic.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    frame_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_WAIT_TICK;
      ST_WAIT_TICK: begin
        if ((tick || pend_q) && !pause_i) begin
          state_d = ST_INPUT;
          pend_d  = 1'b0;
        end else if (tick) begin
          pend_d = 1'b1;
        end
      end
      ST_INPUT, ST_ACTION, ST_DISPLAY: begin
        if (tick) begin
          pend_d = 1'b1;
          ovr_d  = 1'b1;
        end
        if (done_cur) begin
          state_d = next_stage(state_q);
          frame_d = (state_q == ST_DISPLAY);
        end else if (wdog_to) begin
          state_d = ST_WAIT_TICK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; everything freezes while ena_i is low,
  // except that the frame pulse is never stretched across a freeze.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= '0;
      en_q        <= '0;
    end else if (ena_i) begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      frame_q <= frame_d;
      if (frame_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      en_q <= {state_d == ST_DISPLAY, state_d == ST_ACTION, state_d == ST_INPUT};
    end else begin
      frame_q <= 1'b0;
    end
  end

  assign e_inp_o     = en_q[0];
  assign e_act_o     = en_q[1];
  assign e_disp_o    = en_q[2];
  assign frame_o     = frame_q;
  assign frame_cnt_o = frame_cnt_q;
  assign overrun_o   = ovr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: a behavioural frame model pushes
// per-cycle expectations and completed-frame counts; monitors pop/compare.
module tb_frame_scheduler;

  localparam int unsigned FD = 8;
  localparam int unsigned WD = 16;

  logic clk_i = 1'b0;
  logic reset_i, ena_i, pause_i, d_inp_i, d_act_i, d_disp_i;
  logic e_inp_o, e_act_o, e_disp_o, frame_o, overrun_o, wdog_err_o;
  logic [15:0] frame_cnt_o;
  logic [2:0]  state_o;

  frame_scheduler #(.FRAME_DIV(FD), .WDOG_CYC(WD)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .ena_i(ena_i), .pause_i(pause_i),
    .d_inp_i(d_inp_i), .d_act_i(d_act_i), .d_disp_i(d_disp_i),
    .e_inp_o(e_inp_o), .e_act_o(e_act_o), .e_disp_o(e_disp_o),
    .frame_o(frame_o), .frame_cnt_o(frame_cnt_o), .overrun_o(overrun_o),
    .wdog_err_o(wdog_err_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  en;
    logic        fr;
    logic [15:0] cnt;
    logic        ovr;
    logic        wdg;
  } snap_t;

  snap_t       snap_q[$];
  logic [15:0] frame_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  // Reference model: stage -1 idle, 0 waiting for tick, 1..3 = input/action/display.
  int          m_stage = -1;
  int unsigned m_phase = 0;
  int unsigned m_age   = 0;
  logic        m_pend = 1'b0, m_ovr = 1'b0, m_wdg = 1'b0, m_fr = 1'b0;
  logic [15:0] m_cnt = '0;

  int          mode = 0;
  int unsigned act_block = 0;
  logic        disp_block = 1'b0;

  task automatic model_update();
    logic       tick;
    logic [2:0] dn;
    snap_t      s;
    m_fr = 1'b0;
    if (reset_i) begin
      m_stage = -1; m_phase = 0; m_age = 0;
      m_pend = 1'b0; m_ovr = 1'b0; m_wdg = 1'b0; m_cnt = '0;
    end else if (ena_i) begin
      dn   = {d_disp_i, d_act_i, d_inp_i};
      tick = 1'b0;
      if (m_stage >= 0) begin
        tick    = (m_phase == FD - 1);
        m_phase = (m_phase + 1) % FD;
      end
      if (m_stage == -1) begin
        m_stage = 0;
      end else if (m_stage == 0) begin
        if ((tick || m_pend) && !pause_i) begin
          m_stage = 1; m_pend = 1'b0; m_age = 0;
        end else if (tick) begin
          m_pend = 1'b1;
        end
      end else begin
        if (tick) begin m_pend = 1'b1; m_ovr = 1'b1; end
        if (dn[m_stage-1]) begin
          m_age = 0;
          if (m_stage == 3) begin
            m_stage = 0;
            m_cnt   = m_cnt + 16'd1;
            m_fr    = 1'b1;
            frame_q.push_back(m_cnt);
          end else begin
            m_stage = m_stage + 1;
          end
        end
`ifdef FRAME_SCHED_WDOG_EN
        else if (m_age == WD - 1) begin
          m_stage = 0; m_wdg = 1'b1; m_age = 0;
        end else begin
          m_age = m_age + 1;
        end
`endif
      end
    end
    s.st  = (m_stage < 0) ? 3'd0 : 3'(m_stage + 1);
    s.en  = (m_stage >= 1) ? 3'(1 << (m_stage - 1)) : 3'd0;
    s.fr  = m_fr;
    s.cnt = m_cnt;
    s.ovr = m_ovr;
    s.wdg = m_wdg;
    snap_q.push_back(s);
  endtask

  task automatic drive_dones();
    if (mode == 0) begin
      d_inp_i = e_inp_o; d_act_i = e_act_o; d_disp_i = e_disp_o;
    end else begin
      d_inp_i  = ($urandom_range(0, 3) == 0);
      d_act_i  = ($urandom_range(0, 3) == 0);
      d_disp_i = ($urandom_range(0, 3) == 0);
    end
    if (e_act_o && act_block > 0) begin
      d_act_i = 1'b0;
      act_block--;
    end
    if (disp_block) d_disp_i = 1'b0;
  endtask

  task automatic cycle();
    drive_dones();
    @(posedge clk_i);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int unsigned lim, input string name);
    int unsigned n = 0;
    while (state_o != st && n < lim) begin
      cycle();
      n++;
    end
    check(name, 32'(state_o), 32'(st));
  endtask

  // Per-cycle monitor against the model's expectation for that edge.
  initial forever begin
    @(negedge clk_i);
    if (snap_q.size() > 0) begin
      snap_t w;
      w = snap_q.pop_front();
      total++;
      if (state_o !== w.st || {e_disp_o, e_act_o, e_inp_o} !== w.en || frame_o !== w.fr ||
          frame_cnt_o !== w.cnt || overrun_o !== w.ovr || wdog_err_o !== w.wdg) begin
        bad++;
        $display("FAIL cyc%0d snap: got st=%0d en=%b fr=%b cnt=%h ovr=%b wdg=%b want st=%0d en=%b fr=%b cnt=%h ovr=%b wdg=%b",
                 cyc, state_o, {e_disp_o, e_act_o, e_inp_o}, frame_o, frame_cnt_o, overrun_o, wdog_err_o,
                 w.st, w.en, w.fr, w.cnt, w.ovr, w.wdg);
      end
    end
  end

  // Frame monitor: each frame_o pulse must match the next expected count.
  initial forever begin
    @(negedge clk_i);
    if (frame_o === 1'b1) begin
      total++;
      if (frame_q.size() == 0) begin
        bad++;
        $display("FAIL frame_evt: unexpected pulse cnt=%h want none", frame_cnt_o);
      end else begin
        logic [15:0] w;
        w = frame_q.pop_front();
        if (frame_cnt_o !== w) begin
          bad++;
          $display("FAIL frame_evt: got cnt=%h want %h", frame_cnt_o, w);
        end
      end
    end
  end

  initial begin
    int unsigned n;
    int unsigned c0;
    reset_i = 1'b1; ena_i = 1'b1; pause_i = 1'b0;
    d_inp_i = 1'b0; d_act_i = 1'b0; d_disp_i = 1'b0;
    cycle(); cycle();
    check("rst_state", 32'(state_o), 0);
    check("rst_en", 32'({e_disp_o, e_act_o, e_inp_o}), 0);
    check("rst_frame", 32'(frame_o), 0);
    check("rst_cnt", 32'(frame_cnt_o), 0);
    check("rst_ovr", 32'(overrun_o), 0);
    check("rst_wdg", 32'(wdog_err_o), 0);
    reset_i = 1'b0;

    // Prompt dones: one frame per FD cycles, no overrun.
    repeat (16) cycle();
    n = 0;
    repeat (32) begin cycle(); if (frame_o) n++; end
    check("frames_per_32", n, 32 / FD);
    check("no_overrun", 32'(overrun_o), 0);

    // Slow action stage forces ticks to land mid-frame.
    act_block = 20;
    repeat (40) cycle();
    check("overrun_set", 32'(overrun_o), 1);

    // Pause while waiting: no stage may start, then one starts immediately.
    wait_state(3'd1, 40, "reach_wait");
    pause_i = 1'b1;
    n = 0;
    repeat (30) begin cycle(); if (e_inp_o || e_act_o || e_disp_o) n++; end
    check("pause_no_en", n, 0);
    pause_i = 1'b0;
    cycle();
    check("pause_release", 32'(e_inp_o), 1);
    repeat (10) cycle();

    // Reset in the middle of ACTION, then counter wrap from 0xFFFF.
    act_block = 50;
    wait_state(3'd3, 40, "reach_action");
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    act_block = 0;
    check("midrst_state", 32'(state_o), 0);
    check("midrst_en", 32'({e_disp_o, e_act_o, e_inp_o}), 0);
    check("midrst_cnt", 32'(frame_cnt_o), 0);
    check("midrst_ovr", 32'(overrun_o), 0);
    @(negedge clk_i);
    #1;
    // Preload so the 16-bit wrap is reached without 65k frames.
    dut.frame_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    n = 0;
    while (!frame_o && n < 40) begin cycle(); n++; end
    check("wrap_cnt", 32'(frame_cnt_o), 0);
    repeat (10) cycle();

`ifdef FRAME_SCHED_WDOG_EN
    // Display never completes: watchdog ends the frame without counting it.
    disp_block = 1'b1;
    wait_state(3'd4, 40, "reach_display");
    c0 = 32'(frame_cnt_o);
    n = 0;
    while (e_disp_o && n < 40) begin cycle(); n++; end
    check("wdog_len", n, WD - 1);
    check("wdog_err", 32'(wdog_err_o), 1);
    check("wdog_cnt", 32'(frame_cnt_o), c0);
    disp_block = 1'b0;
    repeat (10) cycle();
`else
    c0 = 0;
    check("wdog_tied", 32'(wdog_err_o), c0);
`endif

    // Random dones, pauses, enables and occasional resets.
    mode = 1;
    repeat (800) begin
      pause_i = ($urandom_range(0, 9) == 0);
      ena_i   = ($urandom_range(0, 9) != 0);
      reset_i = ($urandom_range(0, 299) == 0);
      cycle();
    end
    mode = 0; ena_i = 1'b1; pause_i = 1'b0; reset_i = 1'b0;
    repeat (20) cycle();
    @(negedge clk_i);
    #1;
    check("frames_drained", frame_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 1000000, meaning clk_i cycles per frame tick (10 Hz at 10 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter WDOG_CYC, default 4096, meaning max cycles a stage may stay enabled without its done; legal range 2..65535.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port ena_i, input, 1 bit; global enable, low freezes all state.
REQ-006 SHALL have port pause_i, input, 1 bit; blocks the start of new frames.
REQ-007 SHALL have ports d_inp_i, d_act_i, d_disp_i, input, 1 bit each; stage done from input, action and display stages.
REQ-008 SHALL have ports e_inp_o, e_act_o, e_disp_o, output, 1 bit each; registered stage enables.
REQ-009 SHALL have port frame_o, output, 1 bit; one-cycle pulse per completed frame.
REQ-010 SHALL have port frame_cnt_o, output, 16 bits; completed-frame count.
REQ-011 SHALL have port overrun_o, output, 1 bit; sticky, tick arrived while a frame was in progress.
REQ-012 SHALL have port wdog_err_o, output, 1 bit; sticky stage timeout flag.
REQ-013 SHALL have port state_o, output, 3 bits; current FSM state, for debug.

Function
REQ-014 SHALL implement states IDLE, WAIT_TICK, INPUT, ACTION, DISPLAY; IDLE->WAIT_TICK on first cycle with ena_i=1.
REQ-015 SHALL run a frame timer counting 0..FRAME_DIV-1 while ena_i=1 in any non-IDLE state; tick is a one-cycle event at terminal count, then wrap to 0.
REQ-016 SHALL, in WAIT_TICK with tick (or pending tick) and pause_i=0, go to INPUT and assert e_inp_o on the next cycle.
REQ-017 SHALL advance INPUT->ACTION on d_inp_i, ACTION->DISPLAY on d_act_i and DISPLAY->WAIT_TICK on d_disp_i; previous enable drops and next enable rises in the same cycle, one cycle after done is sampled.
REQ-018 SHALL keep at most one of e_inp_o, e_act_o, e_disp_o high in any cycle.
REQ-019 SHALL ignore done inputs not belonging to the current state.
REQ-020 SHALL pulse frame_o and increment frame_cnt_o (mod 2^16, 0xFFFF->0x0000) on the DISPLAY->WAIT_TICK transition.
REQ-021 SHALL, on a tick outside WAIT_TICK, set one pending-tick bit and set overrun_o; further ticks while pending is set are dropped; pending clears when consumed.
REQ-022 SHALL, with pause_i=1 in WAIT_TICK, hold in WAIT_TICK and keep at most one pending tick; pause_i has no effect on a frame already started.
REQ-023 SHALL, with ena_i=0, hold state, timers, counters and all outputs unchanged, and not pulse frame_o.

Reset
REQ-024 SHALL, on reset_i=1 at a clock edge, set state IDLE, all enables 0, frame_o 0, frame_cnt_o 0, overrun_o 0, wdog_err_o 0, timers 0 and pending 0, regardless of ena_i or current state (mid-frame included).

Configuration
REQ-025 SHALL, with macro FRAME_SCHED_WDOG_EN defined, count cycles in INPUT/ACTION/DISPLAY; at WDOG_CYC cycles without the matching done, drop the enable, set wdog_err_o and go to WAIT_TICK without frame_o; a done in the same cycle as timeout wins.
REQ-026 SHALL, without FRAME_SCHED_WDOG_EN, contain no watchdog counter, tie wdog_err_o to 0 and wait for done indefinitely.

Structure
REQ-027 SHALL take state encoding and default FRAME_DIV/WDOG_CYC constants from shared package flappy_pkg.
REQ-028 SHALL place the frame divider in sub-module frame_timer (clk_i, reset_i, ena_i, tick_o).

Verification
REQ-029 SHALL cover: FRAME_DIV=8, dones returned 1 cycle after each enable -> e_inp_o rises 1 cycle after tick, frame_o pulses once per 8 cycles, frame_cnt_o 0,1,2,...
REQ-030 SHALL cover: d_act_i held 20 cycles before delay, FRAME_DIV=8 -> overrun_o=1, exactly one extra frame starts right after DISPLAY completes.
REQ-031 SHALL cover: pause_i=1 for 30 cycles in WAIT_TICK -> no enable asserts; after release one frame starts within 1 cycle.
REQ-032 SHALL cover: FRAME_SCHED_WDOG_EN, WDOG_CYC=16, d_disp_i never asserted -> e_disp_o drops after 16 cycles, wdog_err_o=1, frame_cnt_o unchanged.
REQ-033 SHALL cover: reset_i during ACTION -> next cycle state IDLE, all outputs 0; frame_cnt preloaded 0xFFFF wraps to 0x0000 on next frame.
